// File: rtl/wishbone_bus_if_pkg.sv
// Shared types for the SRAM-port to Wishbone B4 classic bridge.
// The state encodings match the core's existing WB_IDLE/WB_BUSY/WB_WAIT_FOR_STALL values.
package wishbone_bus_if_pkg;

    typedef enum logic [1:0] {
        WB_IDLE           = 2'b00,
        WB_BUSY           = 2'b01,
        WB_WAIT_FOR_STALL = 2'b11
    } wb_state_e;

    // Width of the pipeline stall vector coming from ctrl.
    localparam int STALL_W = 6;

endpackage

// File: rtl/wishbone_bus_if_if.sv
// Wishbone B4 classic bus bundle between the bridge (master) and a slave.
// Handshake: a transfer is requested while cyc and stb are both high; the
// slave completes it by raising ack for one cycle (rdata valid in that same
// cycle for reads). The master holds addr/wdata/we/sel stable until ack.
interface wishbone_bus_if_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W-1:0]   rdata;
    logic                we;
    logic [DATA_W/8-1:0] sel;
    logic                stb;
    logic                cyc;
    logic                ack;

    modport master (
        output addr, wdata, we, sel, stb, cyc,
        input  rdata, ack
    );

    modport slave (
        input  addr, wdata, we, sel, stb, cyc,
        output rdata, ack
    );
endinterface

// File: rtl/wishbone_bus_if.sv
// Bridges one openmips SRAM-style port onto a Wishbone B4 classic master.
// stallreq holds the pipeline until the slave acks; read data is kept in
// rd_buf while other requesters keep the pipeline stalled.
// Optional feature: define WB_BUS_TIMEOUT_EN to force-terminate a transfer
// after TIMEOUT_CYCLES busy cycles without ack (returns zero data).
module wishbone_bus_if
    import wishbone_bus_if_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall_i,
    input  logic                cpu_ce_i,
    input  logic                cpu_we_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [DATA_W-1:0]   cpu_data_i,
    input  logic [DATA_W/8-1:0] cpu_sel_i,
    output logic [DATA_W-1:0]   cpu_data_o,
    output logic                stallreq,
    output logic                bus_timeout_o,
    output wb_state_e           state_dbg,
    output logic [DATA_W-1:0]   rd_buf_dbg,
    wishbone_bus_if_if.master   wb
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("wishbone_bus_if: TIMEOUT_CYCLES must be at least 1");
    end

    wb_state_e         state;
    wb_state_e         state_next;
    logic [DATA_W-1:0] rd_buf;
    logic [DATA_W-1:0] done_data;
    logic              bus_done;
    logic              timeout_hit;

    assign state_dbg  = state;
    assign rd_buf_dbg = rd_buf;

`ifdef WB_BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] timeout_cnt;

    // Count busy cycles of the current transfer; cleared whenever BUSY ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_cnt <= '0;
        end else if (state == WB_BUSY && !bus_done) begin
            timeout_cnt <= timeout_cnt + 1'b1;
        end else begin
            timeout_cnt <= '0;
        end
    end

    assign timeout_hit = (state == WB_BUSY) &&
                         (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the combinational cpu-side outputs; reset forces them quiet.
    always_comb begin
        state_next    = state;
        stallreq      = 1'b0;
        cpu_data_o    = '0;
        bus_timeout_o = 1'b0;
        bus_done      = 1'b0;
        done_data     = '0;
        if (!rst) begin
            case (state)
                WB_IDLE: begin
                    stallreq = cpu_ce_i;
                    if (cpu_ce_i) begin
                        state_next = WB_BUSY;
                    end
                end
                WB_BUSY: begin
                    stallreq = 1'b1;
                    // A real ack on the terminal cycle wins over the timeout.
                    if (wb.ack || timeout_hit) begin
                        bus_done      = 1'b1;
                        stallreq      = 1'b0;
                        bus_timeout_o = !wb.ack;
                        if (wb.ack && !wb.we) begin
                            done_data = wb.rdata;
                        end
                        cpu_data_o = done_data;
                        state_next = (stall_i != '0) ? WB_WAIT_FOR_STALL : WB_IDLE;
                    end
                end
                WB_WAIT_FOR_STALL: begin
                    cpu_data_o = rd_buf;
                    if (stall_i == '0) begin
                        state_next = WB_IDLE;
                    end
                end
                default: begin
                    state_next = WB_IDLE;
                end
            endcase
        end
    end

    // Bus-side registers: latch the request in IDLE, release the bus on completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb.addr  <= '0;
            wb.wdata <= '0;
            wb.we    <= 1'b0;
            wb.sel   <= '0;
            wb.stb   <= 1'b0;
            wb.cyc   <= 1'b0;
            rd_buf   <= '0;
        end else if (state == WB_IDLE && cpu_ce_i) begin
            wb.addr  <= cpu_addr_i;
            wb.wdata <= cpu_data_i;
            wb.we    <= cpu_we_i;
            wb.sel   <= cpu_sel_i;
            wb.stb   <= 1'b1;
            wb.cyc   <= 1'b1;
        end else if (bus_done) begin
            wb.we    <= 1'b0;
            wb.sel   <= '0;
            wb.stb   <= 1'b0;
            wb.cyc   <= 1'b0;
            rd_buf   <= done_data;
        end
    end

endmodule
